// File: rtl/alu_cmd_pkg.sv
// Shared definitions for the ALU command issuer: sizes, FSM states and ALU select codes.
package alu_cmd_pkg;

    localparam int unsigned DATA_W = 4;
    localparam int unsigned NREG   = 4;
    localparam int unsigned ADDR_W = $clog2(NREG);

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StIssue = 2'd1,
        StResp  = 2'd2
    } state_t;

    // sel[3]=0 arithmetic (sel[2:1] picks the y-side term, sel[0] is carry-in), sel[3]=1 logic
    localparam logic [3:0] SEL_PASS = 4'b0000;
    localparam logic [3:0] SEL_INC  = 4'b0001;
    localparam logic [3:0] SEL_ADD  = 4'b0010;
    localparam logic [3:0] SEL_ADDC = 4'b0011;
    localparam logic [3:0] SEL_SUBB = 4'b0100;
    localparam logic [3:0] SEL_SUB  = 4'b0101;
    localparam logic [3:0] SEL_DEC  = 4'b0110;
    localparam logic [3:0] SEL_AND  = 4'b1000;
    localparam logic [3:0] SEL_OR   = 4'b1001;
    localparam logic [3:0] SEL_XOR  = 4'b1010;
    localparam logic [3:0] SEL_NOT  = 4'b1011;

endpackage

// File: rtl/alu_regfile.sv
// 4x4-bit register file: two asynchronous read ports, one synchronous write port,
// synchronous active-low clear.
module alu_regfile
    import alu_cmd_pkg::*;
(
    input  logic              i_clk,
    input  logic              i_reset_n,
    input  logic [ADDR_W-1:0] i_raddr_a,
    output logic [DATA_W-1:0] o_rdata_a,
    input  logic [ADDR_W-1:0] i_raddr_b,
    output logic [DATA_W-1:0] o_rdata_b,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_waddr,
    input  logic [DATA_W-1:0] i_wdata
);

    logic [DATA_W-1:0] r_mem [NREG];

    // Clear dominates any write so an aborted command leaves nothing behind.
    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            for (int i = 0; i < int'(NREG); i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata_a = r_mem[i_raddr_a];
    assign o_rdata_b = r_mem[i_raddr_b];

endmodule

// File: rtl/alu_cmd_issuer.sv
// Command-side master for an external 4-bit combinational ALU. Reads operands from a
// register file, issues them for one cycle, writes the result back, keeps a carry flag
// and returns each result over valid/ready.
// Optional build macro ALU_CMD_CARRY_CHAIN_EN adds cmd_chain, which substitutes the stored
// carry for sel[0] on arithmetic ops (multiword add/sub).
module alu_cmd_issuer
    import alu_cmd_pkg::*;
(
    input  logic              clk,
    input  logic              reset_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_load,
    input  logic [3:0]        cmd_op,
    input  logic [ADDR_W-1:0] cmd_rd,
    input  logic [ADDR_W-1:0] cmd_rs,
    input  logic [ADDR_W-1:0] cmd_rt,
    input  logic [DATA_W-1:0] cmd_imm,
`ifdef ALU_CMD_CARRY_CHAIN_EN
    input  logic              cmd_chain,
`endif
    output logic [DATA_W-1:0] alu_x,
    output logic [DATA_W-1:0] alu_y,
    output logic [3:0]        alu_sel,
    input  logic [DATA_W-1:0] alu_out,
    input  logic              alu_cout,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic              rsp_cout
);

    state_t              r_state;
    logic [ADDR_W-1:0]   r_rd;
    logic                r_logic;
    logic                r_carry;
    logic [DATA_W-1:0]   r_alu_x;
    logic [DATA_W-1:0]   r_alu_y;
    logic [3:0]          r_alu_sel;
    logic                r_rsp_valid;
    logic [DATA_W-1:0]   r_rsp_data;
    logic                r_rsp_cout;

    logic [DATA_W-1:0]   w_rdata_a;
    logic [DATA_W-1:0]   w_rdata_b;
    logic                w_we;
    logic [ADDR_W-1:0]   w_waddr;
    logic [DATA_W-1:0]   w_wdata;
    logic [3:0]          w_sel;

    assign cmd_ready = reset_n && (r_state == StIdle);

    // Select code to register at accept; chaining only affects arithmetic ops.
    always_comb begin
        w_sel = cmd_op;
`ifdef ALU_CMD_CARRY_CHAIN_EN
        if (cmd_chain && !cmd_op[3]) begin
            w_sel[0] = r_carry;
        end
`endif
    end

    // Writeback: loads write at accept, ALU ops at the ISSUE->RESP edge.
    always_comb begin
        w_we    = 1'b0;
        w_waddr = cmd_rd;
        w_wdata = cmd_imm;
        case (r_state)
            StIdle: begin
                w_we = cmd_valid && cmd_load;
            end
            StIssue: begin
                w_we    = 1'b1;
                w_waddr = r_rd;
                w_wdata = alu_out;
            end
            default: ;
        endcase
    end

    alu_regfile u_regfile (
        .i_clk     (clk),
        .i_reset_n (reset_n),
        .i_raddr_a (cmd_rs),
        .o_rdata_a (w_rdata_a),
        .i_raddr_b (cmd_rt),
        .o_rdata_b (w_rdata_b),
        .i_we      (w_we),
        .i_waddr   (w_waddr),
        .i_wdata   (w_wdata)
    );

    // Control FSM with registered ALU drive, carry flag and response outputs.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state     <= StIdle;
            r_rd        <= '0;
            r_logic     <= 1'b0;
            r_carry     <= 1'b0;
            r_alu_x     <= '0;
            r_alu_y     <= '0;
            r_alu_sel   <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_data  <= '0;
            r_rsp_cout  <= 1'b0;
        end else begin
            case (r_state)
                StIdle: begin
                    if (cmd_valid) begin
                        if (cmd_load) begin
                            r_rsp_valid <= 1'b1;
                            r_rsp_data  <= cmd_imm;
                            r_rsp_cout  <= 1'b0;
                            r_state     <= StResp;
                        end else begin
                            r_alu_x   <= w_rdata_a;
                            r_alu_y   <= w_rdata_b;
                            r_alu_sel <= w_sel;
                            r_rd      <= cmd_rd;
                            r_logic   <= cmd_op[3];
                            r_state   <= StIssue;
                        end
                    end
                end
                StIssue: begin
                    r_rsp_valid <= 1'b1;
                    r_rsp_data  <= alu_out;
                    if (r_logic) begin
                        r_rsp_cout <= 1'b0;
                    end else begin
                        r_rsp_cout <= alu_cout;
                        r_carry    <= alu_cout;
                    end
                    r_state <= StResp;
                end
                StResp: begin
                    if (rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_state     <= StIdle;
                    end
                end
                default: begin
                    r_state <= StIdle;
                end
            endcase
        end
    end

    assign alu_x     = r_alu_x;
    assign alu_y     = r_alu_y;
    assign alu_sel   = r_alu_sel;
    assign rsp_valid = r_rsp_valid;
    assign rsp_data  = r_rsp_data;
    assign rsp_cout  = r_rsp_cout;

endmodule

// File: tb/tb_alu_cmd_issuer.sv
// Self-checking bench for alu_cmd_issuer with a behavioural model of the external ALU.
module tb_alu_cmd_issuer;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       cmd_valid;
    logic       cmd_ready;
    logic       cmd_load;
    logic [3:0] cmd_op;
    logic [1:0] cmd_rd;
    logic [1:0] cmd_rs;
    logic [1:0] cmd_rt;
    logic [3:0] cmd_imm;
    logic       cmd_chain;
    logic [3:0] alu_x;
    logic [3:0] alu_y;
    logic [3:0] alu_sel;
    logic [3:0] alu_out;
    logic       alu_cout;
    logic       rsp_valid;
    logic       rsp_ready;
    logic [3:0] rsp_data;
    logic       rsp_cout;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    alu_cmd_issuer dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_load  (cmd_load),
        .cmd_op    (cmd_op),
        .cmd_rd    (cmd_rd),
        .cmd_rs    (cmd_rs),
        .cmd_rt    (cmd_rt),
        .cmd_imm   (cmd_imm),
`ifdef ALU_CMD_CARRY_CHAIN_EN
        .cmd_chain (cmd_chain),
`endif
        .alu_x     (alu_x),
        .alu_y     (alu_y),
        .alu_sel   (alu_sel),
        .alu_out   (alu_out),
        .alu_cout  (alu_cout),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_cout  (rsp_cout)
    );

    // ALU model: x + {0, y, ~y, 1111}[sel[2:1]] + sel[0]; logic ops override the result.
    // The adder carry is left visible on logic ops so the issuer must mask it itself.
    always_comb begin
        logic [3:0] b;
        logic [4:0] sum;
        case (alu_sel[2:1])
            2'b00:   b = 4'h0;
            2'b01:   b = alu_y;
            2'b10:   b = ~alu_y;
            default: b = 4'hF;
        endcase
        sum      = {1'b0, alu_x} + {1'b0, b} + {4'b0, alu_sel[0]};
        alu_cout = sum[4];
        if (alu_sel[3]) begin
            case (alu_sel[1:0])
                2'b00:   alu_out = alu_x & alu_y;
                2'b01:   alu_out = alu_x | alu_y;
                2'b10:   alu_out = alu_x ^ alu_y;
                default: alu_out = ~alu_x;
            endcase
        end else begin
            alu_out = sum[3:0];
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Issue one command, wait for its response, then handshake it. lat counts clock edges
    // from the accept edge to the first edge at which rsp_valid is seen high.
    task automatic do_cmd(input logic ld, input logic [3:0] op, input logic [1:0] rd,
                          input logic [1:0] rs, input logic [1:0] rt, input logic [3:0] imm,
                          input logic ch, output logic [3:0] d, output logic c,
                          output int lat);
        int wait_n;
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_load  = ld;
        cmd_op    = op;
        cmd_rd    = rd;
        cmd_rs    = rs;
        cmd_rt    = rt;
        cmd_imm   = imm;
        cmd_chain = ch;
        wait_n = 0;
        while (!cmd_ready && wait_n < 20) begin
            @(negedge clk);
            wait_n++;
        end
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        lat = 1;
        @(negedge clk);
        while (!rsp_valid && lat < 10) begin
            @(negedge clk);
            lat++;
        end
        d = rsp_data;
        c = rsp_cout;
        rsp_ready = 1'b1;
        @(posedge clk);
        #1 rsp_ready = 1'b0;
    endtask

    typedef struct {
        logic       load;
        logic [3:0] op;
        logic [1:0] rd;
        logic [1:0] rs;
        logic [1:0] rt;
        logic [3:0] imm;
        logic [3:0] exp_data;
        logic       exp_cout;
        int         exp_lat;
    } vec_t;

    localparam int NVEC = 15;
    vec_t vecs [NVEC];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] d;
        logic       c;
        int         lat;

        //            load op      rd    rs    rt    imm   data  c  lat
        vecs[0]  = '{1'b1, 4'h0, 2'd1, 2'd0, 2'd0, 4'h7, 4'h7, 1'b0, 1};
        vecs[1]  = '{1'b1, 4'h0, 2'd2, 2'd0, 2'd0, 4'h3, 4'h3, 1'b0, 1};
        vecs[2]  = '{1'b0, 4'h2, 2'd0, 2'd1, 2'd2, 4'h0, 4'hA, 1'b0, 2}; // 7+3
        vecs[3]  = '{1'b1, 4'h0, 2'd1, 2'd0, 2'd0, 4'hF, 4'hF, 1'b0, 1};
        vecs[4]  = '{1'b1, 4'h0, 2'd2, 2'd0, 2'd0, 4'h1, 4'h1, 1'b0, 1};
        vecs[5]  = '{1'b0, 4'h2, 2'd3, 2'd1, 2'd2, 4'h0, 4'h0, 1'b1, 2}; // F+1 wraps
        vecs[6]  = '{1'b0, 4'h5, 2'd3, 2'd2, 2'd1, 4'h0, 4'h2, 1'b0, 2}; // 1-F
        vecs[7]  = '{1'b0, 4'h0, 2'd3, 2'd3, 2'd3, 4'h0, 4'h2, 1'b0, 2}; // pass r3
        vecs[8]  = '{1'b0, 4'h1, 2'd0, 2'd0, 2'd0, 4'h0, 4'hB, 1'b0, 2}; // A+1
        vecs[9]  = '{1'b0, 4'h6, 2'd1, 2'd1, 2'd0, 4'h0, 4'hE, 1'b1, 2}; // F-1
        vecs[10] = '{1'b0, 4'h4, 2'd0, 2'd0, 2'd2, 4'h0, 4'h9, 1'b1, 2}; // B-1-1
        vecs[11] = '{1'b0, 4'h3, 2'd2, 2'd2, 2'd2, 4'h0, 4'h3, 1'b0, 2}; // 1+1+1
        vecs[12] = '{1'b0, 4'h8, 2'd3, 2'd0, 2'd1, 4'h0, 4'h8, 1'b0, 2}; // 9&E
        vecs[13] = '{1'b0, 4'hB, 2'd1, 2'd1, 2'd0, 4'h0, 4'h1, 1'b0, 2}; // ~E
        vecs[14] = '{1'b0, 4'h9, 2'd0, 2'd0, 2'd3, 4'h0, 4'h9, 1'b0, 2}; // 9|8

        reset_n   = 1'b0;
        cmd_valid = 1'b1;
        cmd_load  = 1'b0;
        cmd_op    = 4'h2;
        cmd_rd    = 2'd0;
        cmd_rs    = 2'd1;
        cmd_rt    = 2'd2;
        cmd_imm   = 4'h5;
        cmd_chain = 1'b0;
        rsp_ready = 1'b0;

        // Reset held for two cycles with a command offered.
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk($sformatf("reset%0d cmd_ready", i), int'(cmd_ready), 0);
            chk($sformatf("reset%0d rsp_valid", i), int'(rsp_valid), 0);
            chk($sformatf("reset%0d rsp_data", i), int'(rsp_data), 0);
            chk($sformatf("reset%0d rsp_cout", i), int'(rsp_cout), 0);
            chk($sformatf("reset%0d alu_x", i), int'(alu_x), 0);
            chk($sformatf("reset%0d alu_y", i), int'(alu_y), 0);
            chk($sformatf("reset%0d alu_sel", i), int'(alu_sel), 0);
        end
        cmd_valid = 1'b0;
        reset_n   = 1'b1;
        @(negedge clk);
        chk("post-reset rsp_valid", int'(rsp_valid), 0);
        chk("post-reset cmd_ready", int'(cmd_ready), 1);

        // Every register reads back 0 (pass through the ALU into itself).
        for (int r = 0; r < 4; r++) begin
            do_cmd(1'b0, 4'h0, 2'(r), 2'(r), 2'(r), 4'h0, 1'b0, d, c, lat);
            chk($sformatf("reset read r%0d", r), int'(d), 0);
        end

        // Table-driven vectors.
        for (int i = 0; i < NVEC; i++) begin
            do_cmd(vecs[i].load, vecs[i].op, vecs[i].rd, vecs[i].rs, vecs[i].rt,
                   vecs[i].imm, 1'b0, d, c, lat);
            chk($sformatf("vec%0d data", i), int'(d), int'(vecs[i].exp_data));
            chk($sformatf("vec%0d cout", i), int'(c), int'(vecs[i].exp_cout));
            chk($sformatf("vec%0d latency", i), lat, vecs[i].exp_lat);
        end
        // Registers now: r0=9 r1=1 r2=3 r3=8.

        // Backpressure: ADD r0=r1+r2=4 held for 5 cycles, next command (load r1=D) waiting.
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_load  = 1'b0;
        cmd_op    = 4'h2;
        cmd_rd    = 2'd0;
        cmd_rs    = 2'd1;
        cmd_rt    = 2'd2;
        @(posedge clk);
        #1;
        cmd_load = 1'b1;
        cmd_rd   = 2'd1;
        cmd_imm  = 4'hD;
        @(negedge clk);
        @(negedge clk);
        for (int k = 0; k < 5; k++) begin
            chk($sformatf("bp%0d rsp_valid", k), int'(rsp_valid), 1);
            chk($sformatf("bp%0d rsp_data", k), int'(rsp_data), 4);
            chk($sformatf("bp%0d cmd_ready", k), int'(cmd_ready), 0);
            @(negedge clk);
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        #1 rsp_ready = 1'b0;
        @(negedge clk);
        chk("bp after handshake rsp_valid", int'(rsp_valid), 0);
        chk("bp after handshake cmd_ready", int'(cmd_ready), 1);
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        @(negedge clk);
        chk("bp queued load rsp_valid", int'(rsp_valid), 1);
        chk("bp queued load rsp_data", int'(rsp_data), 4'hD);
        rsp_ready = 1'b1;
        @(posedge clk);
        #1 rsp_ready = 1'b0;

        // XOR masks carry and leaves the flag alone; then chained add after a carry-out.
        do_cmd(1'b1, 4'h0, 2'd0, 2'd0, 2'd0, 4'hC, 1'b0, d, c, lat);
        do_cmd(1'b1, 4'h0, 2'd1, 2'd0, 2'd0, 4'h5, 1'b0, d, c, lat);
        do_cmd(1'b1, 4'h0, 2'd2, 2'd0, 2'd0, 4'h0, 1'b0, d, c, lat);
        do_cmd(1'b0, 4'h0, 2'd0, 2'd0, 2'd0, 4'h0, 1'b0, d, c, lat); // clears carry
        chk("pass r0 data", int'(d), 4'hC);
        do_cmd(1'b0, 4'hA, 2'd3, 2'd0, 2'd1, 4'h0, 1'b0, d, c, lat);
        chk("xor data", int'(d), 4'h9);
        chk("xor cout", int'(c), 0);
        do_cmd(1'b0, 4'h2, 2'd2, 2'd2, 2'd2, 4'h0, 1'b1, d, c, lat);
        chk("chain after xor data", int'(d), 4'h0);
        do_cmd(1'b1, 4'h0, 2'd0, 2'd0, 2'd0, 4'hF, 1'b0, d, c, lat);
        do_cmd(1'b1, 4'h0, 2'd1, 2'd0, 2'd0, 4'h1, 1'b0, d, c, lat);
        do_cmd(1'b0, 4'h2, 2'd0, 2'd0, 2'd1, 4'h0, 1'b0, d, c, lat);
        chk("F+1 data", int'(d), 4'h0);
        chk("F+1 cout", int'(c), 1);
        do_cmd(1'b1, 4'h0, 2'd3, 2'd0, 2'd0, 4'h4, 1'b0, d, c, lat);
        chk("load with carry set cout", int'(c), 0);
        do_cmd(1'b0, 4'h2, 2'd2, 2'd2, 2'd2, 4'h0, 1'b1, d, c, lat);
`ifdef ALU_CMD_CARRY_CHAIN_EN
        chk("chain add data", int'(d), 4'h1);
`else
        chk("chain add data", int'(d), 4'h0);
`endif

        // Reset during ISSUE aborts: no response, destination cleared.
        do_cmd(1'b1, 4'h0, 2'd3, 2'd0, 2'd0, 4'h6, 1'b0, d, c, lat);
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_load  = 1'b0;
        cmd_op    = 4'h2;
        cmd_rd    = 2'd3;
        cmd_rs    = 2'd3;
        cmd_rt    = 2'd3;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        chk("mid-op reset rsp_valid", int'(rsp_valid), 0);
        chk("mid-op reset cmd_ready", int'(cmd_ready), 0);
        reset_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk($sformatf("after abort%0d rsp_valid", k), int'(rsp_valid), 0);
        end
        do_cmd(1'b0, 4'h0, 2'd3, 2'd3, 2'd3, 4'h0, 1'b0, d, c, lat);
        chk("after abort r3", int'(d), 0);
        chk("after abort latency", lat, 2);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
